query_stream_buffer: RTL and testbench

QUERY_STREAM_BUFFER -- requirements
Module: query_stream_buffer

---
 rtl/query_stream_buffer_if.sv | 32 +++
 rtl/query_stream_buffer.sv | 136 +++++++++++++
 tb/tb_query_stream_buffer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/query_stream_buffer_if.sv
// rtl/query_stream_buffer_if.sv - symbol stream, pop request and status bundle for query_stream_buffer
interface query_stream_buffer_if #(
   parameter int DATA_W = 2,
   parameter int DEPTH  = 16
);
   localparam int LVL_W = $clog2(DEPTH + 1);

   logic [DATA_W:0]  sym_i;
   logic             pouring_i;
   logic [1:0]       pop_i;
   logic             flush_i;
   logic [DATA_W:0]  q0_o;
   logic [DATA_W:0]  q1_o;
   logic [LVL_W-1:0] level_o;
   logic             full_o;
   logic             almost_full_o;
   logic             ready_one_o;
   logic             ready_two_o;
   logic             overflow_o;

   modport master (
      output sym_i, pouring_i, pop_i, flush_i,
      input  q0_o, q1_o, level_o, full_o, almost_full_o,
             ready_one_o, ready_two_o, overflow_o
   );

   modport slave (
      input  sym_i, pouring_i, pop_i, flush_i,
      output q0_o, q1_o, level_o, full_o, almost_full_o,
             ready_one_o, ready_two_o, overflow_o
   );
endinterface

// File: rtl/query_stream_buffer.sv
// rtl/query_stream_buffer.sv - circular query symbol buffer with two-entry registered lookahead
module query_stream_buffer #(
   parameter int DATA_W    = 2,
   parameter int DEPTH     = 16,
   parameter int AF_MARGIN = 2
) (
   input logic                   clk,
   input logic                   rst,
   query_stream_buffer_if.slave  bus
);
   localparam int LVL_W = $clog2(DEPTH + 1);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int ENT_W = DATA_W + 1;
   localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);
   localparam logic [LVL_W-1:0] AF_L    = LVL_W'(DEPTH - AF_MARGIN);

   // Pointer advance by 0..2 with wrap done by comparison, so DEPTH need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input logic [1:0] n);
      logic [PTR_W:0] s;
      s = {1'b0, p} + {{(PTR_W-1){1'b0}}, n};
      if (s >= (PTR_W+1)'(DEPTH))
         s = s - (PTR_W+1)'(DEPTH);
      return s[PTR_W-1:0];
   endfunction

   logic [ENT_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr, wr_ptr;
   logic [LVL_W-1:0] level;
   logic             pending;
   logic             pouring_last;
   logic             overflow;

   logic [ENT_W-1:0] q0_r, q1_r;
   logic [LVL_W-1:0] level_r;
   logic             full_r, af_r, r1_r, r2_r;

   logic             sym_valid;
   logic [1:0]       pop_req, eff_pop;
   logic [LVL_W-1:0] after_pop;
   logic             slot, term_fire, push, drop, fall, do_write;
   logic [ENT_W-1:0] wdata;
   logic [PTR_W-1:0] rd_n, rd1_n, wr_n;
   logic [LVL_W-1:0] lvl_n;
   logic             pend_n, ovf_n;
   logic [ENT_W-1:0] q0_n, q1_n;

   // Next-state: clamp the pop to what is stored, accept a symbol or the terminator, then flush overrides.
   always_comb begin
      sym_valid = bus.sym_i[ENT_W-1];
      pop_req   = (bus.pop_i == 2'd3) ? 2'd2 : bus.pop_i;
      eff_pop   = ({{(LVL_W-2){1'b0}}, pop_req} > level) ? level[1:0] : pop_req;
      after_pop = level - {{(LVL_W-2){1'b0}}, eff_pop};
      slot      = after_pop < DEPTH_L;
      term_fire = pending & ~sym_valid & slot;
      push      = (sym_valid & slot) | term_fire;
      drop      = sym_valid & ~slot;
      wdata     = term_fire ? '0 : bus.sym_i;
      fall      = pouring_last & ~bus.pouring_i;

      do_write  = push & ~bus.flush_i;
      rd_n      = bus.flush_i ? '0 : ptr_add(rd_ptr, eff_pop);
      wr_n      = bus.flush_i ? '0 : (push ? ptr_add(wr_ptr, 2'd1) : wr_ptr);
      lvl_n     = bus.flush_i ? '0 : after_pop + LVL_W'(push);
      // A pending terminator swallows any further falling edge until it is written.
      pend_n    = bus.flush_i ? 1'b0 : (pending ? ~term_fire : fall);
      ovf_n     = bus.flush_i ? 1'b0 : (overflow | drop);

      rd1_n     = ptr_add(rd_n, 2'd1);
      // The slot being written this cycle is read through the bypass so a fresh entry shows next cycle.
      q0_n      = '0;
      q1_n      = '0;
      if (lvl_n >= LVL_W'(1))
         q0_n = (do_write && rd_n == wr_ptr) ? wdata : mem[rd_n];
      if (lvl_n >= LVL_W'(2))
         q1_n = (do_write && rd1_n == wr_ptr) ? wdata : mem[rd1_n];
   end

   // Control state: pointers, occupancy, terminator and overflow flags, edge detector.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         level        <= '0;
         pending      <= 1'b0;
         pouring_last <= 1'b0;
         overflow     <= 1'b0;
      end else begin
         rd_ptr       <= rd_n;
         wr_ptr       <= wr_n;
         level        <= lvl_n;
         pending      <= pend_n;
         pouring_last <= bus.pouring_i;
         overflow     <= ovf_n;
      end
   end

   // Entry storage, cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else if (do_write) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Registered lookahead and status derived from the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q0_r    <= '0;
         q1_r    <= '0;
         level_r <= '0;
         full_r  <= 1'b0;
         af_r    <= 1'b0;
         r1_r    <= 1'b0;
         r2_r    <= 1'b0;
      end else begin
         q0_r    <= q0_n;
         q1_r    <= q1_n;
         level_r <= lvl_n;
         full_r  <= (lvl_n == DEPTH_L);
         af_r    <= (lvl_n >= AF_L);
         r1_r    <= (lvl_n >= LVL_W'(1));
         r2_r    <= (lvl_n >= LVL_W'(2));
      end
   end

   assign bus.q0_o          = q0_r;
   assign bus.q1_o          = q1_r;
   assign bus.level_o       = level_r;
   assign bus.full_o        = full_r;
   assign bus.almost_full_o = af_r;
   assign bus.ready_one_o   = r1_r;
   assign bus.ready_two_o   = r2_r;
   assign bus.overflow_o    = overflow;
endmodule

// File: tb/tb_query_stream_buffer.sv
// tb/tb_query_stream_buffer.sv - randomized and directed checks of query_stream_buffer against a queue model
module tb_query_stream_buffer;
   localparam int DATA_W    = 2;
   localparam int DEPTH     = 16;
   localparam int AF_MARGIN = 2;
   localparam int ENT_W     = DATA_W + 1;
   localparam int LVL_W     = $clog2(DEPTH + 1);

   logic clk = 1'b0;
   logic rst = 1'b1;

   query_stream_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

   query_stream_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference: a queue of stored entries plus the terminator and overflow rules.
   logic [ENT_W-1:0] mq [$];
   logic m_pend = 1'b0;
   logic m_last = 1'b0;
   logic m_ovf  = 1'b0;
   int   m_npop;
   logic m_fall, m_fired;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
         m_pend = 1'b0;
         m_last = 1'b0;
         m_ovf  = 1'b0;
      end else begin
         m_npop = (bus.pop_i == 2'd3) ? 2 : int'(bus.pop_i);
         if (m_npop > mq.size()) m_npop = mq.size();
         m_fall  = m_last && !bus.pouring_i;
         m_fired = 1'b0;
         if (bus.flush_i) begin
            mq.delete();
            m_pend = 1'b0;
            m_ovf  = 1'b0;
         end else begin
            for (int k = 0; k < m_npop; k++) mq.delete(0);
            if (bus.sym_i[ENT_W-1]) begin
               if (mq.size() < DEPTH) mq.push_back(bus.sym_i);
               else m_ovf = 1'b1;
            end else if (m_pend && mq.size() < DEPTH) begin
               mq.push_back('0);
               m_fired = 1'b1;
            end
            m_pend = m_pend ? !m_fired : m_fall;
         end
         m_last = bus.pouring_i;
      end
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   task automatic cmp_model();
      logic [ENT_W-1:0] q0e, q1e;
      int lv;
      lv  = mq.size();
      q0e = (lv >= 1) ? mq[0] : '0;
      q1e = (lv >= 2) ? mq[1] : '0;
      n_vec++;
      if (bus.q0_o !== q0e || bus.q1_o !== q1e || bus.level_o !== LVL_W'(lv) ||
          bus.full_o !== (lv == DEPTH) || bus.almost_full_o !== (lv >= DEPTH - AF_MARGIN) ||
          bus.ready_one_o !== (lv >= 1) || bus.ready_two_o !== (lv >= 2) || bus.overflow_o !== m_ovf) begin
         n_err++;
         $display("FAIL model_cmp t=%0t got q0=%b q1=%b lvl=%0d f=%b af=%b r1=%b r2=%b ov=%b required q0=%b q1=%b lvl=%0d ov=%b",
                  $time, bus.q0_o, bus.q1_o, bus.level_o, bus.full_o, bus.almost_full_o,
                  bus.ready_one_o, bus.ready_two_o, bus.overflow_o, q0e, q1e, lv, m_ovf);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      cmp_model();
   endtask

   task automatic drive(input logic [ENT_W-1:0] s, input logic [1:0] p, input logic f);
      bus.sym_i   = s;
      bus.pop_i   = p;
      bus.flush_i = f;
   endtask

   task automatic fill16();
      for (int i = 0; i < DEPTH; i++) begin
         drive({1'b1, 2'(i)}, 2'd0, 1'b0);
         cyc();
      end
      drive('0, 2'd0, 1'b0);
   endtask

   initial begin
      bus.sym_i = '0; bus.pouring_i = 1'b0; bus.pop_i = '0; bus.flush_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_level", 32'(bus.level_o), 32'd0);
      chk("rst_q0", 32'(bus.q0_o), 32'd0);
      chk("rst_ready_one", 32'(bus.ready_one_o), 32'd0);
      rst = 1'b0;

      // three pushes, no pop
      drive(3'b101, 2'd0, 1'b0); cyc();
      drive(3'b110, 2'd0, 1'b0); cyc();
      drive(3'b111, 2'd0, 1'b0); cyc();
      drive('0, 2'd0, 1'b0);
      chk("push3_level", 32'(bus.level_o), 32'd3);
      chk("push3_q0", 32'(bus.q0_o), 32'b101);
      chk("push3_q1", 32'(bus.q1_o), 32'b110);
      chk("push3_ready_two", 32'(bus.ready_two_o), 32'd1);
      chk("push3_full", 32'(bus.full_o), 32'd0);

      // fill to full, almost-full threshold, drop on 17th
      drive('0, 2'd0, 1'b1); cyc();
      for (int i = 0; i < DEPTH; i++) begin
         drive({1'b1, 2'(i)}, 2'd0, 1'b0);
         cyc();
         if (i == 12) chk("af_at_13", 32'(bus.almost_full_o), 32'd0);
         if (i == 13) chk("af_at_14", 32'(bus.almost_full_o), 32'd1);
      end
      chk("full_at_16", 32'(bus.full_o), 32'd1);
      drive(3'b111, 2'd0, 1'b0); cyc();
      chk("drop_overflow", 32'(bus.overflow_o), 32'd1);
      chk("drop_level", 32'(bus.level_o), 32'd16);

      // push + pop2 at full, then drain through the wrap
      drive('0, 2'd0, 1'b1); cyc();
      fill16();
      drive(3'b100, 2'd2, 1'b0); cyc();
      chk("fullpp_level", 32'(bus.level_o), 32'd15);
      chk("fullpp_overflow", 32'(bus.overflow_o), 32'd0);
      chk("fullpp_q0", 32'(bus.q0_o), 32'b110);
      chk("fullpp_q1", 32'(bus.q1_o), 32'b111);
      for (int i = 0; i < 7; i++) begin
         drive('0, 2'd3, 1'b0); cyc();
      end
      chk("wrap_tail_q0", 32'(bus.q0_o), 32'b100);
      chk("wrap_tail_ready_two", 32'(bus.ready_two_o), 32'd0);

      // pop 2 at level 1, then at level 0
      drive('0, 2'd2, 1'b0); cyc();
      chk("under_level", 32'(bus.level_o), 32'd0);
      chk("under_q0", 32'(bus.q0_o), 32'd0);
      chk("under_ready_one", 32'(bus.ready_one_o), 32'd0);
      cyc();
      chk("under_empty_level", 32'(bus.level_o), 32'd0);

      // end of query while two more symbols arrive
      drive('0, 2'd0, 1'b1); cyc();
      bus.pouring_i = 1'b1; drive(3'b101, 2'd0, 1'b0); cyc();
      bus.pouring_i = 1'b0; drive(3'b110, 2'd0, 1'b0); cyc();
      drive(3'b111, 2'd0, 1'b0); cyc();
      drive('0, 2'd0, 1'b0); cyc();
      chk("term_level", 32'(bus.level_o), 32'd4);
      cyc(); cyc();
      chk("term_once_level", 32'(bus.level_o), 32'd4);
      drive('0, 2'd2, 1'b0); cyc();
      drive('0, 2'd0, 1'b0);
      chk("term_q0", 32'(bus.q0_o), 32'b111);
      chk("term_q1", 32'(bus.q1_o), 32'b000);

      // flush overrides push/pop with overflow set
      drive('0, 2'd0, 1'b1); cyc();
      fill16();
      drive(3'b101, 2'd0, 1'b0); cyc();
      for (int i = 0; i < 5; i++) begin
         drive('0, 2'd2, 1'b0); cyc();
      end
      drive('0, 2'd1, 1'b0); cyc();
      chk("preflush_level", 32'(bus.level_o), 32'd5);
      chk("preflush_overflow", 32'(bus.overflow_o), 32'd1);
      drive(3'b110, 2'd1, 1'b1); cyc();
      drive('0, 2'd0, 1'b0);
      chk("flush_level", 32'(bus.level_o), 32'd0);
      chk("flush_q0", 32'(bus.q0_o), 32'd0);
      chk("flush_overflow", 32'(bus.overflow_o), 32'd0);

      // asynchronous reset mid-operation
      drive(3'b101, 2'd0, 1'b0); cyc(); cyc();
      drive('0, 2'd0, 1'b0);
      #3 rst = 1'b1;
      #1;
      chk("arst_level", 32'(bus.level_o), 32'd0);
      chk("arst_q0", 32'(bus.q0_o), 32'd0);
      cmp_model();
      cyc(); cyc();
      rst = 1'b0;
      drive(3'b111, 2'd0, 1'b0); cyc();
      drive('0, 2'd0, 1'b0);
      chk("post_rst_level", 32'(bus.level_o), 32'd1);
      chk("post_rst_q0", 32'(bus.q0_o), 32'b111);

      // random traffic, alternating pop bias to reach both full and empty
      for (int blk = 0; blk < 15; blk++) begin
         for (int c = 0; c < 200; c++) begin
            bus.sym_i     = ($urandom_range(0, 9) < 6) ? {1'b1, DATA_W'($urandom)} : {1'b0, DATA_W'($urandom)};
            bus.pop_i     = blk[0] ? 2'($urandom_range(0, 3)) : (($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0);
            bus.flush_i   = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 9) == 0) bus.pouring_i = ~bus.pouring_i;
            cyc();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
